// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : wb_pkg
//  Purpose  : Shared widths, register-file constants and the writeback slot
//             record used by the register-file write-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  // One buffered writeback: valid flag, destination register, value.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_slot.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slot
//  Purpose  : One-entry writeback buffer. Loads on a handshake, empties when
//             its entry is granted, and a load on the grant edge replaces the
//             departing entry so a lone requester keeps one write per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_slot
  import wb_pkg::*;
#(
  parameter int SLOT_DATA_W = DATA_W,
  parameter int SLOT_ADDR_W = ADDR_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   load_i,
  input  logic                   grant_i,
  input  logic [SLOT_ADDR_W-1:0] addr_i,
  input  logic [SLOT_DATA_W-1:0] data_i,
  output logic                   vld_o,
  output logic [SLOT_ADDR_W-1:0] addr_o,
  output logic [SLOT_DATA_W-1:0] data_o
);

  logic                   vld_q,  vld_d;
  logic [SLOT_ADDR_W-1:0] addr_q, addr_d;
  logic [SLOT_DATA_W-1:0] data_q, data_d;

  // Next entry: a load wins over a grant so load+grant keeps the slot full.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load_i) begin
      vld_d  = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (grant_i) begin
      vld_d  = 1'b0;
    end
  end

  // Entry register; reset discards any buffered write.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule : wb_slot
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Two-source write-port arbiter for the 32x32 register file.
//             Each source owns a one-entry slot; the single write port is
//             granted oldest-first, round-robin on a same-edge tie. Publishes
//             a pending-write mask for the hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic              vld0, vld1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic [1:0]        grant;
  logic              load0, load1;

  // rr_q: slot favoured on a tie. old1_q: slot 1 holds the older entry.
  // tie_q: both entries arrived on the same edge, so age is undefined.
  logic rr_q,   rr_d;
  logic old1_q, old1_d;
  logic tie_q,  tie_d;

  // Readiness depends on registered state and clr only, never on valid.
  assign req0_ready = ~clr & (~vld0 | grant[0]);
  assign req1_ready = ~clr & (~vld1 | grant[1]);
  assign load0      = req0_valid & req0_ready;
  assign load1      = req1_valid & req1_ready;

  wb_slot #(.SLOT_DATA_W(DATA_W), .SLOT_ADDR_W(ADDR_W)) u_slot0 (
    .clk     (clk),
    .clr     (clr),
    .load_i  (load0),
    .grant_i (grant[0]),
    .addr_i  (req0_addr),
    .data_i  (req0_data),
    .vld_o   (vld0),
    .addr_o  (addr0),
    .data_o  (data0)
  );

  wb_slot #(.SLOT_DATA_W(DATA_W), .SLOT_ADDR_W(ADDR_W)) u_slot1 (
    .clk     (clk),
    .clr     (clr),
    .load_i  (load1),
    .grant_i (grant[1]),
    .addr_i  (req1_addr),
    .data_i  (req1_data),
    .vld_o   (vld1),
    .addr_o  (addr1),
    .data_o  (data1)
  );

  // Grant: single valid slot wins; two valid slots go oldest-first, tie by rr.
  always_comb begin
    grant = 2'b00;
    case ({vld1, vld0})
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (tie_q)       grant[rr_q] = 1'b1;
        else if (old1_q) grant       = 2'b10;
        else             grant       = 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

  // Age and round-robin bookkeeping for the next edge.
  always_comb begin
    rr_d   = rr_q;
    old1_d = old1_q;
    tie_d  = tie_q;
    if (grant[0])      rr_d = 1'b1;
    else if (grant[1]) rr_d = 1'b0;
    if (load0 & load1) begin
      tie_d  = 1'b1;
    end else if (load0 & vld1 & ~grant[1]) begin
      old1_d = 1'b1;
      tie_d  = 1'b0;
    end else if (load1 & vld0 & ~grant[0]) begin
      old1_d = 1'b0;
      tie_d  = 1'b0;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      rr_q   <= 1'b0;
      old1_q <= 1'b0;
      tie_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      old1_q <= old1_d;
      tie_q  <= tie_d;
    end
  end

  // Write-port mux; a write to r0 still takes its grant but is suppressed.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (grant[0]) begin
      wr_addr = addr0;
      wr_data = data0;
    end else if (grant[1]) begin
      wr_addr = addr1;
      wr_data = data1;
    end
    wr_en = (|grant) & (wr_addr != ADDR_W'(ZERO_REG));
  end

  // Pending-write mask: one-hot of each buffered destination, r0 excluded.
  always_comb begin
    pend_mask = '0;
    if (vld0) pend_mask[addr0] = 1'b1;
    if (vld1) pend_mask[addr1] = 1'b1;
    pend_mask[ZERO_REG] = 1'b0;
  end

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed bench for regfile_wb_arbiter. A queue-based model of
//             buffered writes (in acceptance order) predicts the outputs every
//             cycle; literal expectations pin the model at key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr,  req1_addr;
  logic [31:0] req0_data,  req1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .clr        (clr),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pend_mask  (pend_mask)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: buffered writes in the order they will leave (oldest first).
  typedef struct {
    int          slot;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_rr = 1'b0;
  bit   m_a0, m_a1;

  function automatic bit m_ready(input int n, input logic c);
    if (c) return 1'b0;
    if (mq.size() == 0) return 1'b1;
    if (mq[0].slot == n) return 1'b1;
    foreach (mq[i]) if (mq[i].slot == n) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].addr != 5'd0) p[mq[i].addr] = 1'b1;
    return p;
  endfunction

  // Model advance on each rising edge.
  initial forever begin
    @(posedge clk);
    m_a0 = req0_valid && m_ready(0, clr);
    m_a1 = req1_valid && m_ready(1, clr);
    if (clr) begin
      mq.delete();
      m_rr = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        m_rr = (mq[0].slot == 0);
        void'(mq.pop_front());
      end
      if (m_a0 && m_a1) begin
        if (!m_rr) begin
          mq.push_back('{0, req0_addr, req0_data});
          mq.push_back('{1, req1_addr, req1_data});
        end else begin
          mq.push_back('{1, req1_addr, req1_data});
          mq.push_back('{0, req0_addr, req0_data});
        end
      end else if (m_a0) begin
        mq.push_back('{0, req0_addr, req0_data});
      end else if (m_a1) begin
        mq.push_back('{1, req1_addr, req1_data});
      end
    end
  end

  // Register file as seen through the DUT's write port.
  logic [31:0] obs [32] = '{default: 32'h0};
  initial forever begin
    @(posedge clk);
    if (wr_en) obs[wr_addr] = wr_data;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    e_en   = (mq.size() > 0) && (mq[0].addr != 5'd0);
    e_addr = (mq.size() > 0) ? mq[0].addr : 5'd0;
    e_data = (mq.size() > 0) ? mq[0].data : 32'd0;
    chk("wr_en",      {31'd0, wr_en},      {31'd0, e_en});
    chk("wr_addr",    {27'd0, wr_addr},    {27'd0, e_addr});
    chk("wr_data",    wr_data,             e_data);
    chk("pend_mask",  pend_mask,           m_pend());
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, m_ready(0, clr)});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, m_ready(1, clr)});
  end

  // Present one cycle of inputs; returns at the falling edge of that cycle.
  task automatic cyc(input logic c,
                     input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    clr = c;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    clr = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;

    // Reset held with both valids high.
    cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    idle();
    chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("post_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("post_rst_wr_data", wr_data, 32'd0);
    chk("post_rst_pend", pend_mask, 32'd0);
    chk("post_rst_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_rdy1", {31'd0, req1_ready}, 32'd1);

    // Simultaneous load: r7 first on the tie, then r8.
    cyc(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd8, 32'hB);
    idle();
    chk("sim_addr0", {27'd0, wr_addr}, 32'd7);
    chk("sim_data0", wr_data, 32'hA);
    chk("sim_pend0", pend_mask, 32'h180);
    chk("sim_rdy1_lo", {31'd0, req1_ready}, 32'd0);
    idle();
    chk("sim_addr1", {27'd0, wr_addr}, 32'd8);
    chk("sim_data1", wr_data, 32'hB);
    chk("sim_pend1", pend_mask, 32'h100);
    chk("sim_rdy1_hi", {31'd0, req1_ready}, 32'd1);
    idle();
    chk("sim_pend2", pend_mask, 32'd0);

    // Single stream from requester 0 at full rate.
    cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'd0);
    chk("str_addr3", {27'd0, wr_addr}, 32'd3);
    chk("str_data3", wr_data, 32'h11);
    cyc(1'b0, 1'b1, 5'd5, 32'h33, 1'b0, 5'd0, 32'd0);
    chk("str_addr4", {27'd0, wr_addr}, 32'd4);
    chk("str_rdy0", {31'd0, req0_ready}, 32'd1);
    idle();
    chk("str_addr5", {27'd0, wr_addr}, 32'd5);
    chk("str_data5", wr_data, 32'h33);
    idle();
    chk("str_done", {31'd0, wr_en}, 32'd0);

    // Age ordering: r6 from req1 points rr at slot 0, then a tie is granted
    // to slot 0 while slot 1 (r9=1) waits; req0 then refills with r9=2.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
    idle();
    chk("age_r6", {27'd0, wr_addr}, 32'd6);
    cyc(1'b0, 1'b1, 5'd10, 32'h5, 1'b1, 5'd9, 32'h1);
    cyc(1'b0, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    chk("age_r10", {27'd0, wr_addr}, 32'd10);
    chk("age_pend0", pend_mask, 32'h600);
    idle();
    chk("age_old_addr", {27'd0, wr_addr}, 32'd9);
    chk("age_old_data", wr_data, 32'h1);
    chk("age_rdy0_lo", {31'd0, req0_ready}, 32'd0);
    idle();
    chk("age_new_data", wr_data, 32'h2);
    chk("age_pend2", pend_mask, 32'h200);
    idle();
    chk("age_final_r9", obs[9], 32'h2);
    chk("age_final_r10", obs[10], 32'h5);

    // Write to r0: consumes a grant, never enables the port.
    cyc(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    idle();
    chk("r0_wr_en", {31'd0, wr_en}, 32'd0);
    chk("r0_wr_data", wr_data, 32'hDEAD);
    chk("r0_pend", pend_mask, 32'd0);
    idle();
    chk("r0_freed", wr_data, 32'd0);

    // Reset mid-flight with both slots full and a handshake offered on the clr edge.
    cyc(1'b0, 1'b1, 5'd11, 32'h77, 1'b1, 5'd12, 32'h88);
    cyc(1'b1, 1'b1, 5'd13, 32'h99, 1'b1, 5'd14, 32'hAA);
    chk("mid_pend_full", pend_mask, 32'h1800);
    idle();
    chk("mid_pend_clr", pend_mask, 32'd0);
    chk("mid_wr_en", {31'd0, wr_en}, 32'd0);
    idle();
    idle();
    chk("mid_r13", obs[13], 32'd0);
    chk("mid_r14", obs[14], 32'd0);
    chk("final_r0", obs[0], 32'd0);
    chk("final_r3", obs[3], 32'h11);
    chk("final_r8", obs[8], 32'hB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scheduler for the 32×32-bit register file. Two writeback sources (requester 0: ALU writeback; requester 1: multdiv/load writeback) each hand over one write per cycle through a valid/ready handshake into a private one-entry slot. The arbiter drives the single register-file write port one write per cycle, oldest-first with round-robin tie-break, and publishes a pending-write mask for the hazard/stall unit.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (32 registers; r0 hardwired zero)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `clr`  in  1  reset; synchronous and active-high
- `req0_valid`  in  1  requester 0 offers a write
- `req0_ready`  out  1  slot 0 can accept this cycle
- `req0_addr`  in  ADDR_W  destination register
- `req0_data`  in  DATA_W  write value
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1
- `wr_en`  out  1  register-file write enable
- `wr_addr`  out  ADDR_W  register-file write address
- `wr_data`  out  DATA_W  register-file write data
- `pend_mask`  out  32  bit a = 1 iff a slot holds a valid write to register a (a ≠ 0)

## Operation
- Slot state per requester: `vld`, `addr`, `data`. Shared state: `rr_ptr` (1 bit), `old1` (1 = slot 1 entry older than slot 0 entry).
- Handshake: transfer on rising edge when `reqN_valid & reqN_ready`. `reqN_ready = ~clr & (~slotN.vld | grantN)`. No combinational path from `reqN_valid` to `reqN_ready`.
- Grant, combinational from registered state only:
  - Neither slot valid: no grant.
  - One slot valid: grant it.
  - Both valid and different ages: grant the older one (slot 1 if `old1`, else slot 0).
  - Both valid and loaded on the same edge (`old1` undefined): grant `rr_ptr`.
- On grant to N: `rr_ptr <= ~N`. Slot N is cleared unless refilled on the same edge.
- Age: when a slot loads while the other slot stays valid and is not granted, the other slot becomes older (`old1` set accordingly). When both load on the same edge, the tie flag is set and `rr_ptr` decides.
- Write port: `wr_addr`/`wr_data` come from the granted slot. `wr_en = grant_any & (granted addr ≠ 0)`. A write to r0 still consumes its grant cycle and frees its slot; no register is written. With no grant, `wr_addr`/`wr_data` are 0.
- `pend_mask`: OR of one-hot(addr) over valid slots; bit 0 is always 0.
- Both slots may target the same register. The older entry is written first, so the later-accepted value is the final one.

## Timing
- Latency: accepted on edge E → `wr_en` high in cycle E+1 if granted immediately → register file captures on edge E+1.
- Throughput: one write per cycle on the port. A requester alone sustains 1/cycle: slot refill and grant happen on the same edge.
- Both requesters streaming: grants alternate. Each requester sees `ready` low every other cycle.
- Reset: while `clr` is high, `req0_ready = req1_ready = 0`. On an edge with `clr` high, both `vld`, `rr_ptr` and `old1` are cleared to 0. In the first cycle after `clr` falls: `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`, `pend_mask = 0`, both readies = 1.
- `clr` mid-operation: buffered writes are discarded without being written; a handshake on the `clr` edge is not accepted.

## Structure
- Shared package `wb_pkg`: `ADDR_W`, `DATA_W`, `NUM_REGS = 32`, `ZERO_REG = 0`, and a slot struct/typedef {vld, addr, data}.
- Sub-module `wb_slot`: the one-entry buffer (load, clear-on-grant, simultaneous load+grant), instantiated twice.
- Top level contains the arbiter, the age/`rr_ptr` logic, the output mux and the `pend_mask` decoder.

## Test plan
- Reset check: hold `clr` 2 cycles with both valids high. Required: readies 0 during reset; after release `wr_en = 0`, `pend_mask = 0`, readies 1.
- Single stream: req0 sends r3 = 0x11, r4 = 0x22, r5 = 0x33 on consecutive cycles. Required: `wr_en` on 3 consecutive cycles starting 1 cycle later, addr 3/4/5 with matching data; `req0_ready` stays 1.
- Simultaneous load: both requesters load on one edge, req0 r7 = 0xA, req1 r8 = 0xB. Required: r7 written first (`rr_ptr = 0`), then r8; `req1_ready` is 1 again in the cycle r8 is written; `pend_mask` = 0x180, then 0x100, then 0.
- Age ordering: req1 loads r9 = 0x1 at edge 1 and is held; req0 loads r9 = 0x2 at edge 2. Required: 0x1 written before 0x2, final r9 = 0x2.
- r0 write: req0 sends r0 = 0xDEAD. Required: slot freed next edge, `wr_en` stays 0, `pend_mask` stays 0.
- Reset mid-flight: both slots valid, then assert `clr` for 1 cycle. Required: no `wr_en` pulse afterwards and `pend_mask = 0`.
